// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM access arbiter: FSM states, grant owners and default limits.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } gnt_t;

  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W       = 3;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the external SRAM port.
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // A request is taken on the cycle its *_addr_ok pulses while *_req is high;
  // the matching *_data_ok is a one-cycle pulse carrying read data or store completion.
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic                data_req;
  logic                data_wr;
  logic [DATA_W/8-1:0] data_wstrb;
  logic [ADDR_W-1:0]   data_addr;
  logic [DATA_W-1:0]   data_wdata;
  logic                data_addr_ok;
  logic                data_data_ok;
  logic [DATA_W-1:0]   data_rdata;

  logic                mem_req;
  logic                mem_wr;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_addr_ok;
  logic                mem_data_ok;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/arb_priority_sel.sv
// Combinational winner pick: data has priority unless fetch has been passed over STARVE_MAX times.
module arb_priority_sel
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                inst_req,
  input  logic                data_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output gnt_t                gnt
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  always_comb begin
    gnt = GNT_NONE;
    if (data_req && (!inst_req || (starve_cnt < STARVE_LIM))) begin
      gnt = GNT_DATA;
    end else if (inst_req) begin
      gnt = GNT_INST;
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Single-outstanding arbiter sharing one SRAM port between instruction fetch and load/store traffic.
module sram_access_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_access_arbiter_if.slave  bus,
  output logic                  busy,
  output state_t                state_o,
  output logic [STARVE_W-1:0]   starve_cnt_o
);

  localparam int                  STRB_W     = DATA_W / 8;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t                state_q, state_d;
  gnt_t                  gnt_q, gnt_d;
  gnt_t                  sel;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  wr_q, wr_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]     data_rdata_q, data_rdata_d;
  logic                  inst_addr_ok_c, data_addr_ok_c;
  logic                  inst_data_ok_c, data_data_ok_c;

  arb_priority_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .inst_req   (bus.inst_req),
    .data_req   (bus.data_req),
    .starve_cnt (starve_q),
    .gnt        (sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= GNT_NONE;
      starve_q     <= '0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      starve_q     <= starve_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    starve_d       = starve_q;
    wr_d           = wr_q;
    wstrb_d        = wstrb_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;
    inst_addr_ok_c = 1'b0;
    data_addr_ok_c = 1'b0;
    inst_data_ok_c = 1'b0;
    data_data_ok_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sel == GNT_DATA) begin
          data_addr_ok_c = 1'b1;
          gnt_d          = GNT_DATA;
          wr_d           = bus.data_wr;
          // Loads never drive byte enables onto the SRAM, whatever the requester presents.
          wstrb_d        = bus.data_wr ? bus.data_wstrb : '0;
          addr_d         = bus.data_addr;
          wdata_d        = bus.data_wdata;
          state_d        = ST_ADDR;
          if (!bus.inst_req)              starve_d = '0;
          else if (starve_q < STARVE_LIM) starve_d = starve_q + 1'b1;
        end else if (sel == GNT_INST) begin
          inst_addr_ok_c = 1'b1;
          gnt_d          = GNT_INST;
          wr_d           = 1'b0;
          wstrb_d        = '0;
          addr_d         = bus.inst_addr;
          wdata_d        = '0;
          starve_d       = '0;
          state_d        = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.mem_addr_ok) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bus.mem_data_ok) begin
          if (gnt_q == GNT_INST) inst_rdata_d = bus.mem_rdata;
          else                   data_rdata_d = bus.mem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        inst_data_ok_c = (gnt_q == GNT_INST);
        data_data_ok_c = (gnt_q == GNT_DATA);
        gnt_d          = GNT_NONE;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.inst_addr_ok = inst_addr_ok_c;
  assign bus.data_addr_ok = data_addr_ok_c;
  assign bus.inst_data_ok = inst_data_ok_c;
  assign bus.data_data_ok = data_data_ok_c;
  assign bus.inst_rdata   = inst_rdata_q;
  assign bus.data_rdata   = data_rdata_q;
  assign bus.mem_req      = (state_q == ST_ADDR);
  assign bus.mem_wr       = wr_q;
  assign bus.mem_wstrb    = wstrb_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign busy             = (state_q != ST_IDLE);
  assign state_o          = state_q;
  assign starve_cnt_o     = starve_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: per-cycle vector table plus stall, starvation and reset sequences.
module tb_sram_access_arbiter;
  import mem_pkg::*;

  logic       clk;
  logic       reset;
  logic       busy;
  state_t     state_o;
  logic [2:0] starve_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  sram_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_access_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .busy         (busy),
    .state_o      (state_o),
    .starve_cnt_o (starve_cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ireq; logic [31:0] iaddr;
    logic dreq; logic dwr; logic [3:0] dwstrb; logic [31:0] daddr; logic [31:0] dwdata;
    logic maok; logic mdok; logic [31:0] mrdata;
    logic e_iaok; logic e_daok; logic e_idok; logic e_ddok;
    logic e_mreq; logic e_mwr; logic [3:0] e_mwstrb; logic [31:0] e_maddr;
    logic e_busy; logic [31:0] e_irdata; logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = '0;
    bus.data_req    = 1'b0;
    bus.data_wr     = 1'b0;
    bus.data_wstrb  = '0;
    bus.data_addr   = '0;
    bus.data_wdata  = '0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  task automatic apply_vec(input vec_t v);
    bus.inst_req    = v.ireq;
    bus.inst_addr   = v.iaddr;
    bus.data_req    = v.dreq;
    bus.data_wr     = v.dwr;
    bus.data_wstrb  = v.dwstrb;
    bus.data_addr   = v.daddr;
    bus.data_wdata  = v.dwdata;
    bus.mem_addr_ok = v.maok;
    bus.mem_data_ok = v.mdok;
    bus.mem_rdata   = v.mrdata;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("vec%0d", i);
    chk({p, ".inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'(v.e_iaok));
    chk({p, ".data_addr_ok"}, 32'(bus.data_addr_ok), 32'(v.e_daok));
    chk({p, ".inst_data_ok"}, 32'(bus.inst_data_ok), 32'(v.e_idok));
    chk({p, ".data_data_ok"}, 32'(bus.data_data_ok), 32'(v.e_ddok));
    chk({p, ".mem_req"},      32'(bus.mem_req),      32'(v.e_mreq));
    chk({p, ".busy"},         32'(busy),             32'(v.e_busy));
    chk({p, ".inst_rdata"},   bus.inst_rdata,        v.e_irdata);
    chk({p, ".data_rdata"},   bus.data_rdata,        v.e_drdata);
    if (v.e_mreq) begin
      chk({p, ".mem_wr"},    32'(bus.mem_wr),    32'(v.e_mwr));
      chk({p, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(v.e_mwstrb));
      chk({p, ".mem_addr"},  bus.mem_addr,       v.e_maddr);
    end
  endtask

  initial begin
    //           ireq iaddr        dreq wr strb   daddr         wdata  maok mdok rdata           iaok daok idok ddok mreq mwr strb  maddr        busy irdata        drdata
    vecs[0]  = '{1'b0, 32'h0,      1'b1,1'b0,4'hF,32'h100,     32'h0, 1'b0,1'b0,32'h0,          1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,      1'b0,32'h0,        32'h0};
    vecs[1]  = '{1'b0, 32'h0,      1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b1,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,4'h0,32'h100,    1'b1,32'h0,        32'h0};
    vecs[2]  = '{1'b0, 32'h0,      1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b0,1'b1,32'hDEADBEEF,   1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,      1'b1,32'h0,        32'h0};
    vecs[3]  = '{1'b0, 32'h0,      1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'h0,32'h0,      1'b1,32'h0,        32'hDEADBEEF};
    vecs[4]  = '{1'b0, 32'h0,      1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,      1'b0,32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b1, 32'h400,    1'b1,1'b0,4'h0,32'h300,     32'h0, 1'b0,1'b0,32'h0,          1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,      1'b0,32'h0,        32'hDEADBEEF};
    vecs[6]  = '{1'b1, 32'h400,    1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b1,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,4'h0,32'h300,    1'b1,32'h0,        32'hDEADBEEF};
    vecs[7]  = '{1'b1, 32'h400,    1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b0,1'b1,32'hA5A5A5A5,   1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,      1'b1,32'h0,        32'hDEADBEEF};
    vecs[8]  = '{1'b1, 32'h400,    1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,4'h0,32'h0,      1'b1,32'h0,        32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 32'h400,    1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b0,1'b0,32'h0,          1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,      1'b0,32'h0,        32'hA5A5A5A5};
    vecs[10] = '{1'b0, 32'h0,      1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b1,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,4'h0,32'h400,    1'b1,32'h0,        32'hA5A5A5A5};
    vecs[11] = '{1'b0, 32'h0,      1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b0,1'b1,32'h11223344,   1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,      1'b1,32'h0,        32'hA5A5A5A5};
    vecs[12] = '{1'b0, 32'h0,      1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b0,1'b0,32'h0,          1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,4'h0,32'h0,      1'b1,32'h11223344, 32'hA5A5A5A5};
    vecs[13] = '{1'b0, 32'h0,      1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b0,1'b1,32'hFFFFFFFF,   1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,      1'b0,32'h11223344, 32'hA5A5A5A5};
    vecs[14] = '{1'b0, 32'h0,      1'b0,1'b0,4'h0,32'h0,       32'h0, 1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'h0,32'h0,      1'b0,32'h11223344, 32'hA5A5A5A5};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk("rst.state",   32'(state_o),      32'(ST_IDLE));
    chk("rst.busy",    32'(busy),         32'h0);
    chk("rst.mem_req", 32'(bus.mem_req),  32'h0);
    chk("rst.starve",  32'(starve_cnt_o), 32'h0);
    chk("rst.drdata",  bus.data_rdata,    32'h0);
    reset = 1'b0;

    // table: single load, simultaneous requests, spurious mem_data_ok in IDLE
    for (int i = 0; i < 15; i++) begin
      tick();
      apply_vec(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // store held off by the SRAM for 3 cycles
    tick();
    idle_inputs();
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'b1100;
    bus.data_addr = 32'h204; bus.data_wdata = 32'h12345678;
    #1;
    chk("st.data_addr_ok", 32'(bus.data_addr_ok), 32'h1);
    for (int c = 0; c < 4; c++) begin
      tick();
      idle_inputs();
      bus.data_addr   = 32'hBAD0_0000 + 32'(c);
      bus.data_wdata  = 32'hFFFF_FFFF;
      bus.mem_addr_ok = (c == 3);
      #1;
      chk($sformatf("st.mem_req%0d", c),   32'(bus.mem_req),   32'h1);
      chk($sformatf("st.mem_wr%0d", c),    32'(bus.mem_wr),    32'h1);
      chk($sformatf("st.mem_addr%0d", c),  bus.mem_addr,       32'h204);
      chk($sformatf("st.mem_wstrb%0d", c), 32'(bus.mem_wstrb), 32'hC);
      chk($sformatf("st.mem_wdata%0d", c), bus.mem_wdata,      32'h12345678);
    end
    tick();
    idle_inputs();
    bus.mem_data_ok = 1'b1;
    #1;
    chk("st.ddok_data", 32'(bus.data_data_ok), 32'h0);
    tick();
    idle_inputs();
    #1;
    chk("st.ddok_resp", 32'(bus.data_data_ok), 32'h1);
    tick();
    #1;
    chk("st.ddok_after", 32'(bus.data_data_ok), 32'h0);
    chk("st.busy_after", 32'(busy),             32'h0);

    // fetch held pending while data keeps asking: 4 data grants, then fetch
    for (int g = 0; g < 5; g++) begin
      if (g > 0) tick();
      idle_inputs();
      bus.inst_req  = 1'b1;
      bus.inst_addr = 32'h800;
      bus.data_req  = 1'b1;
      bus.data_addr = 32'h500 + 32'(g * 4);
      #1;
      chk($sformatf("sv%0d.data_addr_ok", g), 32'(bus.data_addr_ok), 32'(g < 4));
      chk($sformatf("sv%0d.inst_addr_ok", g), 32'(bus.inst_addr_ok), 32'(g == 4));
      tick();
      bus.data_req    = 1'b0;
      bus.mem_addr_ok = 1'b1;
      #1;
      chk($sformatf("sv%0d.starve", g),   32'(starve_cnt_o), (g < 4) ? 32'(g + 1) : 32'h0);
      chk($sformatf("sv%0d.mem_addr", g), bus.mem_addr,      (g < 4) ? 32'h500 + 32'(g * 4) : 32'h800);
      tick();
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b1;
      bus.mem_rdata   = 32'hC0DE_0000 + 32'(g);
      tick();
      bus.mem_data_ok = 1'b0;
      #1;
      chk($sformatf("sv%0d.ddok", g), 32'(bus.data_data_ok), 32'(g < 4));
      chk($sformatf("sv%0d.idok", g), 32'(bus.inst_data_ok), 32'(g == 4));
    end
    chk("sv.inst_rdata", bus.inst_rdata, 32'hC0DE_0004);
    chk("sv.data_rdata", bus.data_rdata, 32'hC0DE_0003);

    // reset while waiting for the SRAM response, then a late response
    tick();
    idle_inputs();
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h40;
    tick();
    bus.data_req    = 1'b0;
    bus.mem_addr_ok = 1'b1;
    tick();
    bus.mem_addr_ok = 1'b0;
    #1;
    chk("rd.state_data", 32'(state_o), 32'(ST_DATA));
    #1;
    reset = 1'b1;
    #1;
    chk("rd.state",   32'(state_o),         32'(ST_IDLE));
    chk("rd.busy",    32'(busy),            32'h0);
    chk("rd.mem_req", 32'(bus.mem_req),     32'h0);
    chk("rd.starve",  32'(starve_cnt_o),    32'h0);
    chk("rd.irdata",  bus.inst_rdata,       32'h0);
    chk("rd.drdata",  bus.data_rdata,       32'h0);
    chk("rd.maddr",   bus.mem_addr,         32'h0);
    tick();
    tick();
    #2;
    reset = 1'b0;
    tick();
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = 32'h0000_0099;
    #1;
    chk("rd.late_ddok", 32'(bus.data_data_ok), 32'h0);
    tick();
    bus.mem_data_ok = 1'b0;
    #1;
    chk("rd.post_ddok",  32'(bus.data_data_ok), 32'h0);
    chk("rd.post_idok",  32'(bus.inst_data_ok), 32'h0);
    chk("rd.post_state", 32'(state_o),          32'(ST_IDLE));
    chk("rd.post_drd",   bus.data_rdata,        32'h0);
    tick();
    #1;
    chk("rd.post2_ddok", 32'(bus.data_data_ok), 32'h0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
